rename_port_arbiter: RTL

RENAME_PORT_ARBITER -- requirements
Module: rename_port_arbiter

---
 rtl/rename_pkg.sv | 14 +
 rtl/retire_fifo.sv | 53 +++++
 rtl/rename_port_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared widths, register-file sizes and the grant-select encoding for the
// rename port arbiter.
package rename_pkg;
    localparam int ARCH_W   = 5;
    localparam int PHYS_W   = 6;
    localparam int NUM_PHYS = 64;
    localparam int NUM_ARCH = 32;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_ISSUE,
        SEL_RETIRE
    } sel_e;
endpackage

// File: rtl/retire_fifo.sv
// Small circular FIFO holding physical tags waiting to be returned to the
// free pool. Push/pop are self-guarded against full/empty.
module retire_fifo #(
    parameter int RQ_DEPTH = 4,
    parameter int W        = 6,
    parameter int CNT_W    = $clog2(RQ_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int AW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(RQ_DEPTH - 1);

    logic [W-1:0]     r_mem [RQ_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_cnt == CNT_W'(RQ_DEPTH));
    assign empty     = (r_cnt == '0);
    assign count     = r_cnt;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop)
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)
                r_cnt <= r_cnt + 1'b1;
            else if (w_do_pop && !w_do_push)
                r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/rename_port_arbiter.sv
// Arbitrates the single rename port between instruction issue and register
// retirement, tracking the free physical register count.
module rename_port_arbiter #(
    parameter int NUM_PHYS   = rename_pkg::NUM_PHYS,
    parameter int NUM_ARCH   = rename_pkg::NUM_ARCH,
    parameter int RQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      iss_req,
    input  logic [rename_pkg::ARCH_W-1:0] iss_rd,
    input  logic [rename_pkg::ARCH_W-1:0] iss_rs1,
    input  logic [rename_pkg::ARCH_W-1:0] iss_rs2,
    output logic                      iss_gnt,
    output logic                      iss_stall,
    input  logic                      ret_req,
    input  logic [rename_pkg::PHYS_W-1:0] ret_phys,
    output logic                      ret_rdy,
    output logic                      issue_valid,
    output logic                      retire_valid,
    output logic [rename_pkg::ARCH_W-1:0] rd,
    output logic [rename_pkg::ARCH_W-1:0] rs1,
    output logic [rename_pkg::ARCH_W-1:0] rs2,
    output logic [rename_pkg::PHYS_W-1:0] retire_phys_reg,
    output logic [6:0]                free_cnt,
    output logic                      err_overflow
);
    import rename_pkg::*;

    localparam int CNT_W = $clog2(RQ_DEPTH + 1);
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [6:0] FREE_MAX = 7'(NUM_PHYS - NUM_ARCH);

    sel_e              w_sel;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_cnt;
    logic [PHYS_W-1:0] w_head;

    logic              r_iss_v;
    logic              r_ret_v;
    logic [ARCH_W-1:0] r_rd, r_rs1, r_rs2;
    logic [PHYS_W-1:0] r_rph;
    logic [6:0]        r_free;
    logic [SW-1:0]     r_starve;
    logic              r_err;

    // Retires win once the queue is nearly full, the pool is dry, nothing
    // wants to issue, or issue has starved retirement long enough.
    always_comb begin
        w_sel = SEL_NONE;
        if (reset)
            w_sel = SEL_NONE;
        else if (w_empty) begin
            if (iss_req && r_free != '0)
                w_sel = SEL_ISSUE;
        end else if (32'(w_cnt) >= RQ_DEPTH - 1 || r_free == '0 || !iss_req ||
                     32'(r_starve) == STARVE_MAX)
            w_sel = SEL_RETIRE;
        else
            w_sel = SEL_ISSUE;
    end

    assign w_push    = ret_req & ~w_full & ~reset;
    assign iss_gnt   = (w_sel == SEL_ISSUE);
    assign iss_stall = iss_req & ~iss_gnt;
    assign ret_rdy   = ~w_full;

    retire_fifo #(.RQ_DEPTH(RQ_DEPTH), .W(PHYS_W), .CNT_W(CNT_W)) u_rq (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_sel == SEL_RETIRE),
        .din   (ret_phys),
        .dout  (w_head),
        .count (w_cnt),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_v  <= 1'b0;
            r_ret_v  <= 1'b0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_rph    <= '0;
            r_free   <= FREE_MAX;
            r_starve <= '0;
            r_err    <= 1'b0;
        end else begin
            r_iss_v <= (w_sel == SEL_ISSUE);
            r_ret_v <= (w_sel == SEL_RETIRE);
            if (w_sel == SEL_ISSUE) begin
                r_rd   <= iss_rd;
                r_rs1  <= iss_rs1;
                r_rs2  <= iss_rs2;
                r_free <= r_free - 1'b1;
            end
            if (w_sel == SEL_RETIRE) begin
                r_rph <= w_head;
                if (r_free == FREE_MAX)
                    r_err <= 1'b1;
                else
                    r_free <= r_free + 1'b1;
            end
            if (ret_req && w_full)
                r_err <= 1'b1;
            if (w_sel == SEL_RETIRE || w_empty)
                r_starve <= '0;
            else if (w_sel == SEL_ISSUE && 32'(r_starve) != STARVE_MAX)
                r_starve <= r_starve + 1'b1;
        end
    end

    assign issue_valid     = r_iss_v;
    assign retire_valid    = r_ret_v;
    assign rd              = r_rd;
    assign rs1             = r_rs1;
    assign rs2             = r_rs2;
    assign retire_phys_reg = r_rph;
    assign free_cnt        = r_free;
    assign err_overflow    = r_err;
endmodule
